// File: rtl/ct_lsu_dcache_data_refill_wr_if.sv
// Refill/read/array bundle for the dcache data-bank refill write sequencer.
// master: upstream refill/pipeline side plus the array model.
// slave : the sequencer itself.
interface ct_lsu_dcache_data_refill_wr_if #(
  parameter int IDX_W  = 11,
  parameter int BEAT_W = 128
);
  logic                refill_req_vld;
  logic [IDX_W-5:0]    refill_req_line;
  logic [1:0]          refill_req_start_beat;
  logic                refill_req_rdy;
  logic                refill_beat_vld;
  logic [BEAT_W-1:0]   refill_beat_data;
  logic                refill_beat_rdy;
  logic                refill_done;
  logic                rd_req_vld;
  logic [IDX_W-1:0]    rd_req_idx;
  logic                rd_dout_vld;
  logic [31:0]         rd_dout;
  logic                data_gateclk_en;
  logic                data_sel_b;
  logic                data_gwen_b;
  logic [3:0]          data_wen_b;
  logic [IDX_W-1:0]    data_idx;
  logic [31:0]         data_din;
  logic [31:0]         data_dout;

  modport master (
    output refill_req_vld, refill_req_line, refill_req_start_beat,
    output refill_beat_vld, refill_beat_data, rd_req_vld, rd_req_idx, data_dout,
    input  refill_req_rdy, refill_beat_rdy, refill_done, rd_dout_vld, rd_dout,
    input  data_gateclk_en, data_sel_b, data_gwen_b, data_wen_b, data_idx, data_din
  );

  modport slave (
    input  refill_req_vld, refill_req_line, refill_req_start_beat,
    input  refill_beat_vld, refill_beat_data, rd_req_vld, rd_req_idx, data_dout,
    output refill_req_rdy, refill_beat_rdy, refill_done, rd_dout_vld, rd_dout,
    output data_gateclk_en, data_sel_b, data_gwen_b, data_wen_b, data_idx, data_din
  );
endinterface

// File: rtl/ct_lsu_dcache_data_refill_wr.sv
// Dcache data-bank refill write sequencer.
// Takes a line refill request and four 128-bit beats, writes each beat as four
// single-word array writes, and shares the array port with pipeline reads
// (reads always win, stalling the pending write by one cycle).
// Optional feature macro: LSU_REFILL_CRITICAL_FIRST_EN -- beats are written in
// wrap order starting at refill_req_start_beat instead of always starting at 0.
module ct_lsu_dcache_data_refill_wr #(
  parameter int IDX_W  = 11,
  parameter int BEAT_W = 128
) (
  input logic                              forever_cpuclk,
  input logic                              cpurst_b,
  ct_lsu_dcache_data_refill_wr_if.slave    bus
);
  localparam int LINE_W = IDX_W - 4;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BEAT = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [1:0]        beats_done_q, beats_done_d;
  logic [BEAT_W-1:0] beat_buf_q, beat_buf_d;
  logic              rd_vld_q;
  logic              done_q, done_d;
  logic              wr_issue;
  logic [1:0]        start_beat;

`ifdef LSU_REFILL_CRITICAL_FIRST_EN
  assign start_beat = bus.refill_req_start_beat;
`else
  logic unused_start_beat;
  assign unused_start_beat = ^bus.refill_req_start_beat;
  assign start_beat = 2'd0;
`endif

  // A pending write only reaches the array when no pipeline read claims the port.
  assign wr_issue = (state_q == WRITE) && !bus.rd_req_vld;

  assign bus.refill_req_rdy  = (state_q == IDLE);
  assign bus.refill_beat_rdy = (state_q == WAIT_BEAT);
  assign bus.refill_done     = done_q;
  assign bus.rd_dout_vld     = rd_vld_q;
  assign bus.rd_dout         = bus.data_dout;
  assign bus.data_gateclk_en = bus.rd_req_vld | wr_issue;

  // Array port mux: read has priority, then refill write, else port parked.
  always_comb begin
    bus.data_sel_b  = 1'b1;
    bus.data_gwen_b = 1'b1;
    bus.data_wen_b  = 4'hF;
    bus.data_idx    = '0;
    bus.data_din    = '0;
    if (bus.rd_req_vld) begin
      bus.data_sel_b = 1'b0;
      bus.data_idx   = bus.rd_req_idx;
    end else if (wr_issue) begin
      bus.data_sel_b  = 1'b0;
      bus.data_gwen_b = 1'b0;
      bus.data_wen_b  = 4'h0;
      bus.data_idx    = {line_q, beat_cnt_q, wcnt_q};
      bus.data_din    = beat_buf_q[{wcnt_q, 5'b0} +: 32];
    end
  end

  // Refill sequencing: request -> beat capture -> four word writes per beat.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    beat_cnt_d   = beat_cnt_q;
    wcnt_d       = wcnt_q;
    beats_done_d = beats_done_q;
    beat_buf_d   = beat_buf_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.refill_req_vld) begin
          line_d       = bus.refill_req_line;
          beat_cnt_d   = start_beat;
          wcnt_d       = 2'd0;
          beats_done_d = 2'd0;
          state_d      = WAIT_BEAT;
        end
      end
      WAIT_BEAT: begin
        if (bus.refill_beat_vld) begin
          beat_buf_d = bus.refill_beat_data;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (wr_issue) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            if (beats_done_q == 2'd3) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              beat_cnt_d   = beat_cnt_q + 2'd1;
              beats_done_d = beats_done_q + 2'd1;
              state_d      = WAIT_BEAT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any refill in flight.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q      <= IDLE;
      line_q       <= '0;
      beat_cnt_q   <= 2'd0;
      wcnt_q       <= 2'd0;
      beats_done_q <= 2'd0;
      beat_buf_q   <= '0;
      rd_vld_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      beat_cnt_q   <= beat_cnt_d;
      wcnt_q       <= wcnt_d;
      beats_done_q <= beats_done_d;
      beat_buf_q   <= beat_buf_d;
      rd_vld_q     <= bus.rd_req_vld;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_ct_lsu_dcache_data_refill_wr.sv
// Directed bench for the dcache data-bank refill write sequencer, with a
// behavioural 1-cycle-latency array attached to the array port.
module tb_ct_lsu_dcache_data_refill_wr;
  logic clk;
  logic cpurst_b;
  int   checks;
  int   failures;
  int   cyc;

  ct_lsu_dcache_data_refill_wr_if bus ();

  ct_lsu_dcache_data_refill_wr dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic [10:0] log_idx [$];
  logic [31:0] log_din [$];
  int          log_cyc [$];
  int          done_cyc [$];
  logic        done_rdy [$];

  // Array model plus write/done logging
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cpurst_b) begin
      if (!bus.data_sel_b && !bus.data_gwen_b) begin
        mem[bus.data_idx] <= bus.data_din;
        log_idx.push_back(bus.data_idx);
        log_din.push_back(bus.data_din);
        log_cyc.push_back(cyc);
      end
      if (!bus.data_sel_b && bus.data_gwen_b)
        bus.data_dout <= mem[bus.data_idx];
      if (bus.refill_done) begin
        done_cyc.push_back(cyc);
        done_rdy.push_back(bus.refill_req_rdy);
      end
    end
  end

  function automatic logic [31:0] wd(input logic [6:0] ln, input int k, input int w);
    return {4'hC, 1'b0, ln, 4'(k), 4'(w), 12'h5A3};
  endfunction

  function automatic logic [127:0] mk_beat(input logic [6:0] ln, input int k);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = wd(ln, k, w);
    return b;
  endfunction

  task automatic clear_logs;
    log_idx.delete(); log_din.delete(); log_cyc.delete();
    done_cyc.delete(); done_rdy.delete();
  endtask

  task automatic send_req(input logic [6:0] ln, input logic [1:0] sb);
    int n = 0;
    bus.refill_req_vld = 1'b1;
    bus.refill_req_line = ln;
    bus.refill_req_start_beat = sb;
    while (!bus.refill_req_rdy && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL req_timeout got rdy=%0b need rdy=1", bus.refill_req_rdy);
    end
    @(posedge clk); #1;
    bus.refill_req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    int n = 0;
    bus.refill_beat_vld = 1'b1;
    bus.refill_beat_data = d;
    while (!bus.refill_beat_rdy && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL beat_timeout got rdy=%0b need rdy=1", bus.refill_beat_rdy);
    end
    @(posedge clk); #1;
    bus.refill_beat_vld = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (done_cyc.size() == 0 && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL done_timeout got done_count=0 need 1");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cpurst_b = 1'b0;
    #2;
    checks++; if (bus.data_sel_b !== 1'b1) begin failures++; $display("FAIL rst_sel_b got %b need 1", bus.data_sel_b); end
    checks++; if (bus.data_gwen_b !== 1'b1) begin failures++; $display("FAIL rst_gwen_b got %b need 1", bus.data_gwen_b); end
    checks++; if (bus.data_wen_b !== 4'hF) begin failures++; $display("FAIL rst_wen_b got %h need f", bus.data_wen_b); end
    checks++; if (bus.refill_req_rdy !== 1'b1) begin failures++; $display("FAIL rst_req_rdy got %b need 1", bus.refill_req_rdy); end
    checks++; if (bus.refill_beat_rdy !== 1'b0) begin failures++; $display("FAIL rst_beat_rdy got %b need 0", bus.refill_beat_rdy); end
    checks++; if (bus.refill_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b need 0", bus.refill_done); end
    checks++; if (bus.rd_dout_vld !== 1'b0) begin failures++; $display("FAIL rst_rd_vld got %b need 0", bus.rd_dout_vld); end
    checks++; if (bus.data_gateclk_en !== 1'b0) begin failures++; $display("FAIL rst_gateclk got %b need 0", bus.data_gateclk_en); end
    checks++; if (bus.data_idx !== 11'h000) begin failures++; $display("FAIL rst_idx got %h need 000", bus.data_idx); end
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_refill_basic;
    int n;
    clear_logs();
    send_req(7'h05, 2'd0);
    for (int k = 0; k < 4; k++) send_beat(mk_beat(7'h05, k));
    wait_done();
    checks++; if (log_idx.size() !== 16) begin failures++; $display("FAIL basic_count got %0d need 16", log_idx.size()); end
    n = (log_idx.size() < 16) ? log_idx.size() : 16;
    for (int i = 0; i < n; i++) begin
      checks++; if (log_idx[i] !== 11'(11'h050 + i)) begin failures++; $display("FAIL basic_idx[%0d] got %h need %h", i, log_idx[i], 11'(11'h050 + i)); end
      checks++; if (log_din[i] !== wd(7'h05, i/4, i%4)) begin failures++; $display("FAIL basic_din[%0d] got %h need %h", i, log_din[i], wd(7'h05, i/4, i%4)); end
    end
    checks++; if (done_cyc.size() !== 1) begin failures++; $display("FAIL basic_done_count got %0d need 1", done_cyc.size()); end
    if (done_cyc.size() > 0 && n > 0) begin
      checks++; if (done_cyc[0] !== log_cyc[n-1] + 1) begin failures++; $display("FAIL basic_done_cycle got %0d need %0d", done_cyc[0], log_cyc[n-1] + 1); end
      checks++; if (done_rdy[0] !== 1'b1) begin failures++; $display("FAIL basic_req_rdy_at_done got %b need 1", done_rdy[0]); end
    end
  endtask

  task automatic test_read_collision;
    int n;
    clear_logs();
    send_req(7'h0A, 2'd0);
    send_beat(mk_beat(7'h0A, 0));
    @(posedge clk); #1;
    bus.rd_req_vld = 1'b1;
    bus.rd_req_idx = 11'h123;
    #1;
    checks++; if (bus.data_idx !== 11'h123) begin failures++; $display("FAIL coll_rd_idx got %h need 123", bus.data_idx); end
    checks++; if (bus.data_gwen_b !== 1'b1) begin failures++; $display("FAIL coll_rd_gwen got %b need 1", bus.data_gwen_b); end
    checks++; if (bus.data_sel_b !== 1'b0) begin failures++; $display("FAIL coll_rd_sel got %b need 0", bus.data_sel_b); end
    checks++; if (bus.data_wen_b !== 4'hF) begin failures++; $display("FAIL coll_rd_wen got %h need f", bus.data_wen_b); end
    checks++; if (bus.data_gateclk_en !== 1'b1) begin failures++; $display("FAIL coll_rd_gateclk got %b need 1", bus.data_gateclk_en); end
    @(posedge clk); #1;
    bus.rd_req_vld = 1'b0;
    #1;
    checks++; if (bus.data_idx !== 11'h0A1) begin failures++; $display("FAIL coll_wr_idx got %h need 0a1", bus.data_idx); end
    checks++; if (bus.data_gwen_b !== 1'b0) begin failures++; $display("FAIL coll_wr_gwen got %b need 0", bus.data_gwen_b); end
    checks++; if (bus.data_din !== wd(7'h0A, 0, 1)) begin failures++; $display("FAIL coll_wr_din got %h need %h", bus.data_din, wd(7'h0A, 0, 1)); end
    checks++; if (bus.rd_dout_vld !== 1'b1) begin failures++; $display("FAIL coll_rd_vld got %b need 1", bus.rd_dout_vld); end
    checks++; if (bus.rd_dout !== 32'hBEEF_1234) begin failures++; $display("FAIL coll_rd_dout got %h need beef1234", bus.rd_dout); end
    @(posedge clk); #1;
    checks++; if (bus.rd_dout_vld !== 1'b0) begin failures++; $display("FAIL coll_rd_vld_drop got %b need 0", bus.rd_dout_vld); end
    for (int k = 1; k < 4; k++) send_beat(mk_beat(7'h0A, k));
    wait_done();
    checks++; if (log_idx.size() !== 16) begin failures++; $display("FAIL coll_count got %0d need 16", log_idx.size()); end
    n = (log_idx.size() < 16) ? log_idx.size() : 16;
    for (int i = 0; i < n; i++) begin
      checks++; if (log_idx[i] !== 11'(11'h0A0 + i) || log_din[i] !== wd(7'h0A, i/4, i%4)) begin
        failures++; $display("FAIL coll_write[%0d] got %h/%h need %h/%h", i, log_idx[i], log_din[i], 11'(11'h0A0 + i), wd(7'h0A, i/4, i%4));
      end
    end
    checks++; if (done_cyc.size() !== 1) begin failures++; $display("FAIL coll_done_count got %0d need 1", done_cyc.size()); end
  endtask

  task automatic test_critical_first;
    int n;
    int bn;
    logic [10:0] e;
    clear_logs();
    send_req(7'h06, 2'd2);
    for (int k = 0; k < 4; k++) send_beat(mk_beat(7'h06, k));
    wait_done();
    checks++; if (log_idx.size() !== 16) begin failures++; $display("FAIL crit_count got %0d need 16", log_idx.size()); end
    n = (log_idx.size() < 16) ? log_idx.size() : 16;
    for (int i = 0; i < n; i++) begin
`ifdef LSU_REFILL_CRITICAL_FIRST_EN
      bn = (2 + i/4) % 4;
`else
      bn = i/4;
`endif
      e = {7'h06, 2'(bn), 2'(i%4)};
      checks++; if (log_idx[i] !== e || log_din[i] !== wd(7'h06, i/4, i%4)) begin
        failures++; $display("FAIL crit_write[%0d] got %h/%h need %h/%h", i, log_idx[i], log_din[i], e, wd(7'h06, i/4, i%4));
      end
    end
    checks++; if (done_cyc.size() !== 1) begin failures++; $display("FAIL crit_done_count got %0d need 1", done_cyc.size()); end
  endtask

  task automatic test_beat_gaps;
    int n;
    clear_logs();
    send_req(7'h11, 2'd0);
    for (int k = 0; k < 4; k++) begin
      send_beat(mk_beat(7'h11, k));
      if (k < 3) begin
        repeat (4) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
          checks++; if (bus.refill_beat_rdy !== 1'b1 || bus.data_gwen_b !== 1'b1) begin
            failures++; $display("FAIL gap_idle[%0d.%0d] got rdy=%b gwen=%b need rdy=1 gwen=1", k, g, bus.refill_beat_rdy, bus.data_gwen_b);
          end
          @(posedge clk); #1;
        end
      end
    end
    wait_done();
    checks++; if (log_idx.size() !== 16) begin failures++; $display("FAIL gap_count got %0d need 16", log_idx.size()); end
    n = (log_idx.size() < 16) ? log_idx.size() : 16;
    for (int i = 0; i < n; i++) begin
      checks++; if (log_idx[i] !== 11'(11'h110 + i) || log_din[i] !== wd(7'h11, i/4, i%4)) begin
        failures++; $display("FAIL gap_write[%0d] got %h/%h need %h/%h", i, log_idx[i], log_din[i], 11'(11'h110 + i), wd(7'h11, i/4, i%4));
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    clear_logs();
    send_req(7'h15, 2'd0);
    send_beat(mk_beat(7'h15, 0));
    send_beat(mk_beat(7'h15, 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpurst_b = 1'b0;
    #1;
    checks++; if (bus.refill_req_rdy !== 1'b1 || bus.refill_beat_rdy !== 1'b0) begin
      failures++; $display("FAIL midrst_state got req_rdy=%b beat_rdy=%b need 1/0", bus.refill_req_rdy, bus.refill_beat_rdy);
    end
    checks++; if (bus.data_sel_b !== 1'b1) begin failures++; $display("FAIL midrst_sel got %b need 1", bus.data_sel_b); end
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (log_idx.size() !== 6) begin failures++; $display("FAIL midrst_count got %0d need 6", log_idx.size()); end
    checks++; if (done_cyc.size() !== 0) begin failures++; $display("FAIL midrst_done got %0d need 0", done_cyc.size()); end
    checks++; if (mem[11'h150] !== wd(7'h15, 0, 0)) begin failures++; $display("FAIL midrst_partial got %h need %h", mem[11'h150], wd(7'h15, 0, 0)); end
    clear_logs();
    send_req(7'h16, 2'd0);
    for (int k = 0; k < 4; k++) send_beat(mk_beat(7'h16, k));
    wait_done();
    checks++; if (log_idx.size() !== 16) begin failures++; $display("FAIL midrst_new_count got %0d need 16", log_idx.size()); end
    n = (log_idx.size() < 16) ? log_idx.size() : 16;
    for (int i = 0; i < n; i++) begin
      checks++; if (log_idx[i] !== 11'(11'h160 + i) || log_din[i] !== wd(7'h16, i/4, i%4)) begin
        failures++; $display("FAIL midrst_write[%0d] got %h/%h need %h/%h", i, log_idx[i], log_din[i], 11'(11'h160 + i), wd(7'h16, i/4, i%4));
      end
    end
    checks++; if (done_cyc.size() !== 1) begin failures++; $display("FAIL midrst_new_done got %0d need 1", done_cyc.size()); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[11'h123] = 32'hBEEF_1234;
    bus.refill_req_vld = 1'b0;
    bus.refill_req_line = '0;
    bus.refill_req_start_beat = '0;
    bus.refill_beat_vld = 1'b0;
    bus.refill_beat_data = '0;
    bus.rd_req_vld = 1'b0;
    bus.rd_req_idx = '0;
    bus.data_dout = '0;
    test_reset();
    test_refill_basic();
    test_read_collision();
    test_critical_first();
    test_beat_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
